regfile_rd: RTL and testbench

Integer register file for the RV32I core: 32 × XLEN storage with one writeback port, two registered read ports, and a pending-write scoreboard. Decode issues source reads and destination reservations. Writeback (ALU/LSU) commits results and clears reservations. The block supplies operand data plus per-operand busy flags that drive the pipeline's load-use stall.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 31 +++
 rtl/regfile_rd.sv | 56 +++++
 tb/tb_regfile_rd.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I core constants and register-index type
package riscv_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NREG     = 32;
    localparam int ZERO_REG = 0;
    typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bit per register with combinational busy lookup
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = riscv_pkg::NREG,
    parameter int AW   = riscv_pkg::REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_rd,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_rd,
    input  logic [AW-1:0] lk1_addr,
    input  logic [AW-1:0] lk2_addr,
    output logic          lk1_busy,
    output logic          lk2_busy
);
    logic [NREG-1:0] pending, set_m, clr_m, keep_m;
    always_comb begin
        set_m    = issue_en ? NREG'(1) << issue_rd : '0;
        clr_m    = wb_en ? NREG'(1) << wb_rd : '0;
        keep_m   = ~(NREG'(1) << ZERO_REG);
        lk1_busy = pending[lk1_addr] & ~(wb_en && wb_rd == lk1_addr);
        lk2_busy = pending[lk2_addr] & ~(wb_en && wb_rd == lk2_addr);
    end
    // set applied after clear so a same-edge reissue keeps the newer reservation
    always_ff @(posedge clk or posedge rst)
        if (rst) pending <= '0;
        else     pending <= ((pending & ~clr_m) | set_m) & keep_m;
endmodule

// File: rtl/regfile_rd.sv
// regfile_rd: 32 x XLEN integer register file, two registered read ports with wb bypass, scoreboard busy
module regfile_rd
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG,
    parameter int AW   = riscv_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    logic [XLEN-1:0] regs [1:NREG-1];
    logic [XLEN-1:0] rs1_nxt, rs2_nxt;
    logic            wb_we;
    always_comb begin
        wb_we   = wb_en && wb_rd != AW'(ZERO_REG);
        rs1_nxt = (rs1_addr == AW'(ZERO_REG)) ? '0 : (wb_en && wb_rd == rs1_addr) ? wb_data : regs[rs1_addr];
        rs2_nxt = (rs2_addr == AW'(ZERO_REG)) ? '0 : (wb_en && wb_rd == rs2_addr) ? wb_data : regs[rs2_addr];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            if (wb_we) regs[wb_rd] <= wb_data;
            if (rd_en) begin
                rs1_data <= rs1_nxt;
                rs2_data <= rs2_nxt;
            end
        end
    regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .lk1_addr (rs1_addr),
        .lk2_addr (rs2_addr),
        .lk1_busy (rs1_busy),
        .lk2_busy (rs2_busy)
    );
endmodule

// File: tb/tb_regfile_rd.sv
// tb_regfile_rd: directed and model-checked random stimulus for regfile_rd
module tb_regfile_rd;
    logic        clk, rst, rd_en, issue_en, wb_en;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [31:0] wb_data, rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    int          errors = 0, checks = 0;
    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic [31:0] e1, e2;
    logic        b1, b2;

    regfile_rd dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_en(issue_en), .issue_rd(issue_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 0; issue_en = 0; wb_en = 0;
    endtask

    initial begin
        rst = 1; rd_en = 0; issue_en = 0; wb_en = 0;
        rs1_addr = 0; rs2_addr = 0; issue_rd = 0; wb_rd = 0; wb_data = 0;
        tick(); tick();
        rst = 0;
        rd_en = 1; rs1_addr = 1; rs2_addr = 31;
        tick();
        chk("reset_rs1_data", rs1_data, 0);
        chk("reset_rs2_data", rs2_data, 0);
        chk("reset_rs1_busy", 32'(rs1_busy), 0);
        chk("reset_rs2_busy", 32'(rs2_busy), 0);

        idle(); wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        tick();
        idle(); rd_en = 1; rs1_addr = 5;
        tick();
        chk("wb_x5_read", rs1_data, 32'hDEADBEEF);

        idle(); wb_en = 1; wb_rd = 0; wb_data = 32'h1234;
        tick();
        idle(); rd_en = 1; rs1_addr = 0;
        tick();
        chk("x0_read_zero", rs1_data, 0);

        idle(); wb_en = 1; wb_rd = 7; wb_data = 32'hA5A5A5A5; rd_en = 1; rs2_addr = 7; rs1_addr = 0;
        tick();
        chk("bypass_rs2", rs2_data, 32'hA5A5A5A5);
        chk("bypass_rs1_x0", rs1_data, 0);

        idle(); rs2_addr = 5;
        tick();
        chk("hold_rd_en0", rs2_data, 32'hA5A5A5A5);

        idle(); issue_en = 1; issue_rd = 9;
        tick();
        idle(); rs1_addr = 9;
        #1 chk("issue_x9_busy", 32'(rs1_busy), 1);
        tick();
        chk("x9_busy_hold", 32'(rs1_busy), 1);
        wb_en = 1; wb_rd = 9; wb_data = 32'hCAFEF00D; rd_en = 1;
        #1 chk("x9_wb_comb_nonbusy", 32'(rs1_busy), 0);
        tick();
        idle();
        #1 chk("x9_cleared", 32'(rs1_busy), 0);
        chk("x9_bypass_data", rs1_data, 32'hCAFEF00D);

        idle(); issue_en = 1; issue_rd = 3; wb_en = 1; wb_rd = 3; wb_data = 32'h55;
        tick();
        idle(); rs1_addr = 3;
        #1 chk("x3_still_pending", 32'(rs1_busy), 1);
        rd_en = 1;
        tick();
        chk("x3_written", rs1_data, 32'h55);
        idle(); wb_en = 1; wb_rd = 3; wb_data = 32'h66;
        tick();
        idle();
        #1 chk("x3_second_wb_clears", 32'(rs1_busy), 0);

        idle(); issue_en = 1; issue_rd = 0;
        tick();
        idle(); rs1_addr = 0; rs2_addr = 0;
        #1 chk("x0_never_busy", 32'(rs1_busy), 0);

        idle(); issue_en = 1; issue_rd = 4;
        tick(); tick();
        idle(); wb_en = 1; wb_rd = 4; wb_data = 32'h44; rs2_addr = 4;
        tick();
        idle();
        #1 chk("reissue_single_clear", 32'(rs2_busy), 0);

        idle(); issue_en = 1; issue_rd = 12;
        tick();
        idle(); rs1_addr = 5; rs2_addr = 12;
        rst = 1;
        #2 chk("async_rst_rs1", rs1_data, 0);
        chk("async_rst_busy", 32'(rs2_busy), 0);
        rst = 0;
        rd_en = 1; rs1_addr = 5; rs2_addr = 7;
        tick();
        chk("post_rst_x5", rs1_data, 0);
        chk("post_rst_x7", rs2_data, 0);

        for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
        e1 = 0; e2 = 0;
        for (int n = 0; n < 300; n++) begin
            rd_en    = $urandom_range(0, 3) != 0;
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            issue_en = $urandom_range(0, 2) == 0;
            issue_rd = 5'($urandom_range(0, 7));
            wb_en    = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            b1 = rs1_addr != 0 && m_pend[rs1_addr] && !(wb_en && wb_rd == rs1_addr);
            b2 = rs2_addr != 0 && m_pend[rs2_addr] && !(wb_en && wb_rd == rs2_addr);
            #1 chk("rnd_busy1", 32'(rs1_busy), 32'(b1));
            chk("rnd_busy2", 32'(rs2_busy), 32'(b2));
            if (rd_en) begin
                e1 = rs1_addr == 0 ? 0 : (wb_en && wb_rd == rs1_addr) ? wb_data : m_regs[rs1_addr];
                e2 = rs2_addr == 0 ? 0 : (wb_en && wb_rd == rs2_addr) ? wb_data : m_regs[rs2_addr];
            end
            if (wb_en && wb_rd != 0) begin m_regs[wb_rd] = wb_data; m_pend[wb_rd] = 0; end
            if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1;
            tick();
            chk("rnd_data1", rs1_data, e1);
            chk("rnd_data2", rs2_data, e2);
        end
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
